// File: rtl/moore_seq_scheduler.sv
// Round-robin front end that time-shares one "1101" Moore detector between two word requesters.
// Words are shifted MSB-first, followed by a two-zero flush; per-word hit counts are returned.
module moore_seq_scheduler #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [WORD_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [WORD_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [CNT_W-1:0]  rsp_count,
    output logic              det_x1,
    input  logic              det_hit,
    output logic              busy
);

    localparam int unsigned BIT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    if (WORD_W < 2) begin : gen_param_check
        $error("WORD_W must be at least 2");
    end

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StFlush,
        StResp
    } state_e;

    state_e            state_q;
    logic [WORD_W-1:0] shreg_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic              last_q;

    logic              grant_valid;
    logic              grant_id;
    logic [WORD_W-1:0] grant_data;
    logic              hit_credit;

    // Tie goes to whichever requester was not served last.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state_q == StIdle) begin
            if (req0_valid && req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~last_q;
            end else if (req0_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    assign grant_data = grant_id ? req1_data : req0_data;
    assign req0_ready = grant_valid && !grant_id;
    assign req1_ready = grant_valid && grant_id;

    // det_hit lags det_x1 by one cycle: SHIFT k>=1 credits bit k-1, FLUSH 0 credits the last bit.
    assign hit_credit = det_hit &&
                        (((state_q == StShift) && (bit_cnt_q != '0)) ||
                         ((state_q == StFlush) && (bit_cnt_q == '0)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            last_q    <= 1'b1;
            det_x1    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_count <= '0;
            busy      <= 1'b0;
        end else begin
            if (hit_credit && (rsp_count != CNT_MAX)) begin
                rsp_count <= rsp_count + CNT_W'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        det_x1    <= grant_data[WORD_W-1];
                        shreg_q   <= {grant_data[WORD_W-2:0], 1'b0};
                        rsp_id    <= grant_id;
                        rsp_count <= '0;
                        last_q    <= grant_id;
                        bit_cnt_q <= '0;
                        busy      <= 1'b1;
                        state_q   <= StShift;
                    end
                end
                StShift: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        det_x1    <= 1'b0;
                        bit_cnt_q <= '0;
                        state_q   <= StFlush;
                    end else begin
                        det_x1    <= shreg_q[WORD_W-1];
                        shreg_q   <= {shreg_q[WORD_W-2:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    end
                end
                StFlush: begin
                    det_x1 <= 1'b0;
                    if (bit_cnt_q == '0) begin
                        bit_cnt_q <= BIT_W'(1);
                    end else begin
                        bit_cnt_q <= '0;
                        rsp_valid <= 1'b1;
                        state_q   <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_moore_seq_scheduler.sv
// Scoreboard bench for moore_seq_scheduler with a behavioural "1101" detector in the loop.
// Expected counts come from a window search over each word; timing from transfer-relative cycles.
module tb_moore_seq_scheduler;

    localparam int W = 8;
    localparam int C = 4;
    localparam int MAX_WAIT = 600;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0] req0_data = '0, req1_data = '0;
    logic         req0_ready, req1_ready;
    logic         rsp_valid, rsp_ready = 1'b1, rsp_id;
    logic [C-1:0] rsp_count;
    logic         det_x1, det_hit, busy;

    moore_seq_scheduler #(.WORD_W(W), .CNT_W(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_count  (rsp_count),
        .det_x1     (det_x1),
        .det_hit    (det_hit),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Detector: in state E exactly when the last four inputs were 1,1,0,1.
    logic [3:0] hist;
    always @(posedge clk or negedge rst) begin
        if (!rst) hist <= 4'b0;
        else      hist <= {hist[2:0], det_x1};
    end
    assign det_hit = (hist == 4'b1101);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ref_count(input logic [W-1:0] w);
        int n = 0;
        int cmax = (1 << C) - 1;
        for (int i = W - 1; i >= 3; i--) begin
            if (w[i -: 4] == 4'b1101) n++;
        end
        return (n > cmax) ? cmax : n;
    endfunction

    typedef struct {
        int id;
        int cnt;
    } exp_t;

    exp_t         sb[$];
    int           log_id[$];
    int           log_cyc[$];
    bit           m_busy = 0;
    bit           m_last = 1;
    bit           rsp_seen = 0;
    int           cur_xc = 0;
    logic [W-1:0] cur_word = '0;
    exp_t         cur_exp;
    int           hs_cycle = 0;

    // Monitor: model of arbitration/timing plus scoreboard pop on each presented response.
    always @(negedge clk) begin
        if (!rst) begin
            check("rst_det_x1", int'(det_x1), 0);
            check("rst_rsp_valid", int'(rsp_valid), 0);
            check("rst_rsp_id", int'(rsp_id), 0);
            check("rst_rsp_count", int'(rsp_count), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_req0_ready", int'(req0_ready), 0);
            check("rst_req1_ready", int'(req1_ready), 0);
            sb.delete();
            m_busy = 0;
            m_last = 1;
            rsp_seen = 0;
        end else begin
            bit g_valid;
            bit g_id;
            int d;
            int exp_x;
            bit exp_rv;
            g_valid = 0;
            g_id = 0;
            if (!m_busy) begin
                if (req0_valid && req1_valid) begin g_valid = 1; g_id = !m_last; end
                else if (req0_valid) begin g_valid = 1; g_id = 0; end
                else if (req1_valid) begin g_valid = 1; g_id = 1; end
            end
            check("req0_ready", int'(req0_ready), int'(g_valid && !g_id));
            check("req1_ready", int'(req1_ready), int'(g_valid && g_id));
            check("busy", int'(busy), int'(m_busy));
            d = cyc - cur_xc;
            exp_x = (m_busy && d >= 0 && d < W) ? int'(cur_word[W-1-d]) : 0;
            check("det_x1", int'(det_x1), exp_x);
            exp_rv = m_busy && (d >= W + 2);
            check("rsp_valid", int'(rsp_valid), int'(exp_rv));
            if (rsp_valid && exp_rv) begin
                if (!rsp_seen) begin
                    if (sb.size() == 0) begin
                        check("rsp_unexpected", 1, 0);
                    end else begin
                        cur_exp = sb.pop_front();
                    end
                end
                check("rsp_id", int'(rsp_id), cur_exp.id);
                check("rsp_count", int'(rsp_count), cur_exp.cnt);
                if (rsp_ready) begin
                    m_busy = 0;
                    rsp_seen = 0;
                    hs_cycle = cyc + 1;
                end else begin
                    rsp_seen = 1;
                end
            end
            if (g_valid) begin
                cur_word = g_id ? req1_data : req0_data;
                sb.push_back('{id: int'(g_id), cnt: ref_count(cur_word)});
                m_busy = 1;
                m_last = g_id;
                cur_xc = cyc + 1;
                log_id.push_back(int'(g_id));
                log_cyc.push_back(cyc + 1);
            end
        end
    end

    // Caller is at posedge+1; returns at posedge+1 just after the transfer edge.
    task automatic send(input int id, input logic [W-1:0] d);
        int t = 0;
        bit done = 0;
        if (id == 0) begin req0_data = d; req0_valid = 1'b1; end
        else         begin req1_data = d; req1_valid = 1'b1; end
        while (!done) begin
            @(negedge clk);
            if (id == 0 ? req0_ready : req1_ready) done = 1;
            else if (++t > MAX_WAIT) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: req%0d no grant after %0d cycles", id, t);
                done = 1;
            end
        end
        @(posedge clk);
        #1;
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((busy || sb.size() != 0) && t < MAX_WAIT) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= MAX_WAIT) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: busy=%0d pending=%0d", busy, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    bit senders_done = 0;

    initial begin
        int base;
        do_reset();

        // Both requesters valid throughout: strict alternation, 12-cycle spacing.
        base = log_id.size();
        fork
            begin send(0, 8'h0D); send(0, 8'h6D); end
            begin send(1, 8'hB4); send(1, 8'h1A); end
        join
        drain();
        if (log_id.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) check("rr_order", log_id[base+i], i % 2);
            for (int i = 1; i < 4; i++)
                check("rr_interval", log_cyc[base+i] - log_cyc[base+i-1], W + 4);
        end else begin
            check("rr_transfers", log_id.size() - base, 4);
        end

        send(0, 8'h0D);
        drain();
        send(1, 8'h6D);
        drain();
        send(0, 8'h06);
        send(0, 8'h80);
        drain();

        // Held-off response: outputs frozen, queued requester waits, grant one cycle after handshake.
        rsp_ready = 1'b0;
        send(0, 8'h6D);
        fork
            send(1, 8'h0D);
            begin
                int t = 0;
                while (!rsp_valid && t < 40) begin @(posedge clk); #1; t++; end
                check("bp_rsp_seen", int'(rsp_valid), 1);
                repeat (5) @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        join
        check("bp_grant_gap", log_cyc[log_cyc.size()-1] - hs_cycle, 1);
        drain();

        // Reset during SHIFT cycle 3, then a clean word.
        send(0, 8'hDD);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        send(0, 8'h0D);
        drain();

        // Randomized traffic with random response back-pressure.
        fork
            begin
                fork
                    repeat (12) begin
                        repeat ($urandom_range(0, 15)) @(posedge clk);
                        #1;
                        send(0, W'($urandom));
                    end
                    repeat (12) begin
                        repeat ($urandom_range(0, 15)) @(posedge clk);
                        #1;
                        send(1, W'($urandom));
                    end
                join
                senders_done = 1;
            end
            begin
                while (!senders_done) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
                rsp_ready = 1'b1;
            end
        join
        drain();
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/moore_seq_scheduler.md
# moore_seq_scheduler

Round-robin scheduler that shares one instance of the team's "1101" Moore sequence detector (input x1, state bit y[3] marks detection) between two word requesters. Each granted word is serialized MSB-first onto the detector input and followed by a two-cycle zero flush, so every word starts from detector state A. Detector hits are counted per word and returned on a response handshake tagged with the requester ID. The block sits between the Tiny Tapeout I/O wrapper and the detector.

## Interface
- WORD_W, 8: bits per request word; must be ≥ 2.
- CNT_W, 4: width of the per-word hit count.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low. The detector instance shares this reset.
- req0_valid / req1_valid  in  1  request word present.
- req0_data / req1_data  in  WORD_W  request word; must be stable while valid.
- req0_ready / req1_ready  out  1  combinational grant; transfer on valid && ready.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester index of the word (0 or 1).
- rsp_count  out  CNT_W  detections within the word.
- det_x1  out  1  registered serial bit driven to detector x1.
- det_hit  in  1  detector state bit y[3]; high only in state E.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, SHIFT, FLUSH, RESP.
- IDLE:
  - Grant goes to one valid requester: req0 if only req0 is valid, req1 if only req1 is valid.
  - If both are valid, grant the requester not granted last. The last-grant pointer resets to "req1", so req0 wins the first tie.
  - reqN_ready = (state==IDLE) && grant==N. At most one ready is high; both are low when no request is valid.
  - On transfer: latch data into the shift register, latch the ID into rsp_id, clear the count, update the pointer, go to SHIFT.
- SHIFT, WORD_W cycles, k = 0..WORD_W-1:
  - det_x1 = word[WORD_W-1-k].
  - det_hit is sampled in cycles k ≥ 1 and credited to bit k-1.
  - After cycle WORD_W-1, go to FLUSH.
- FLUSH, 2 cycles, det_x1 = 0 in both:
  - In cycle 0, det_hit (response to the last data bit) is counted.
  - det_hit is ignored in cycle 1.
  - Two zeros return the detector to state A from any state. This guarantees no cross-word detection.
  - Then go to RESP.
- RESP:
  - rsp_valid = 1; rsp_id and rsp_count are held stable.
  - On rsp_valid && rsp_ready, go to IDLE.
  - rsp_ready may already be high in the first RESP cycle.
- Counting:
  - rsp_count increments by 1 per credited det_hit.
  - It saturates at 2^CNT_W-1 and never wraps.
  - With the defaults, at most 2 hits fit in 8 bits.
- Overlap: hits may overlap within a word (0x6D gives 2).
- Unsupported input: a requester that drops valid without a transfer is ignored; no error is flagged.

## Timing
- Reset values: state IDLE, det_x1=0, rsp_valid=0, rsp_id=0, rsp_count=0, busy=0, both ready=0, pointer=req1.
- Reset mid-operation: the in-flight word and count are discarded. The detector is reset in the same event.
- Transfer at edge E0:
  - det_x1 carries bit WORD_W-1 in the cycle after E0.
  - rsp_valid rises at edge E0+WORD_W+2.
  - With rsp_ready high, the earliest next transfer is at edge E0+WORD_W+4.
  - Minimum issue interval is WORD_W+4 cycles: WORD_W SHIFT + 2 FLUSH + 1 RESP + 1 IDLE grant cycle.
- Ready timing:
  - Ready never asserts outside IDLE.
  - A request arriving during a busy period waits; its valid must stay high until its grant.
- det_hit latency: one cycle. The detector is Moore and updates on the edge that ends the det_x1 cycle.
- Response back-pressure: rsp_ready may stay low indefinitely. Outputs hold, and no grant is issued meanwhile.

## Test plan
- req0 sends 0x0D (00001101) -> one transfer; rsp_valid at E0+10; rsp_id=0, rsp_count=1.
- req1 sends 0x6D (01101101) -> rsp_id=1, rsp_count=2 (overlapping hits).
- req0 sends 0x06, then 0x80 back-to-back -> both counts 0. The flush blocks a cross-word "1101".
- Both requesters valid continuously, rsp_ready=1, 4 words -> grant order 0,1,0,1; transfers exactly 12 cycles apart.
- After response 1 appears, rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_id and rsp_count stable; ready stays 0; after the handshake, the next grant follows 1 cycle later.
- rst pulsed low during SHIFT cycle 3 of 0xDD -> all outputs at reset values immediately. Then 0x0D sent -> count 1, with no residue from the aborted word.
